// File: rtl/nnet_framer_pkg.sv
// nnet_framer_pkg: shared constants for the neural-net vector framer.
//   SR_OFF_*  : settings-bus offsets from SR_BASE (size_in, size_out, spp)
//   TUSER_W   : width of the per-vector header carried across the core
//   DEF_SIZE  : reset value of size_in, size_out and spp
package nnet_framer_pkg;
    localparam int SR_OFF_SIZE_IN  = 0;
    localparam int SR_OFF_SIZE_OUT = 1;
    localparam int SR_OFF_SPP      = 2;
    localparam int TUSER_W         = 128;
    localparam int DEF_SIZE        = 1;
endpackage

// File: rtl/nnet_hdr_fifo.sv
// nnet_hdr_fifo: synchronous header FIFO, DEPTH entries of W bits.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : synchronous flush of pointers and occupancy
//   push, din       : write request and data (accepted when not full, or full with pop)
//   pop             : read request (ignored when empty)
//   full, empty     : occupancy flags
//   head            : oldest entry, forced to 0 while empty
module nnet_hdr_fifo
    import nnet_framer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = TUSER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign head  = empty ? '0 : mem_q[rd_q];

    // Pop is taken first, so a push into a full FIFO succeeds when paired with a pop.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        rd_d  = clear ? '0 : rd_q + AW'(do_pop);
        wr_d  = clear ? '0 : wr_q + AW'(do_push);
        cnt_d = clear ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/nnet_vector_framer.sv
// nnet_vector_framer: slices the sample stream into size_in vectors for an HLS core,
// re-frames results into size_out vectors / spp packets, and carries each vector's
// tuser header across the core in a HDR_DEPTH-deep FIFO.
//   ce_clk, ce_rst_n          : clock, asynchronous active-low reset
//   clear                     : synchronous flush of counters/FIFO, promotes pending settings
//   set_stb/set_addr/set_data : settings bus (SR_BASE+0 size_in, +1 size_out, +2 spp)
//   i_*                       : stream from axi_wrapper (tuser sampled on first beat of a vector)
//   m_axis_*                  : stream to the core
//   s_axis_*                  : results from the core
//   o_*                       : stream back to axi_wrapper, o_tuser = header FIFO head
//   size_in/size_out/spp      : active settings
//   vec_in_cnt/vec_out_cnt    : free-running vector counters
//   hdr_stall                 : sticky, result seen while no header was available
// Build option NNET_FRAMER_PAD_EN: a short vector ended by i_tlast is zero-padded to size_in.
module nnet_vector_framer
    import nnet_framer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RES_W     = 16,
    parameter int SIZE_W    = 16,
    parameter int HDR_DEPTH = 4,
    parameter int SR_BASE   = 129
) (
    input  logic                ce_clk,
    input  logic                ce_rst_n,
    input  logic                clear,
    input  logic                set_stb,
    input  logic [7:0]          set_addr,
    input  logic [31:0]         set_data,
    input  logic [DATA_W-1:0]   i_tdata,
    input  logic                i_tlast,
    input  logic                i_tvalid,
    output logic                i_tready,
    input  logic [TUSER_W-1:0]  i_tuser,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic [RES_W-1:0]    s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   o_tdata,
    output logic                o_tlast,
    output logic                o_tvalid,
    input  logic                o_tready,
    output logic [TUSER_W-1:0]  o_tuser,
    output logic [SIZE_W-1:0]   size_in,
    output logic [SIZE_W-1:0]   size_out,
    output logic [SIZE_W-1:0]   spp,
    output logic [31:0]         vec_in_cnt,
    output logic [31:0]         vec_out_cnt,
    output logic                hdr_stall
);
    localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

    logic [SIZE_W-1:0] size_in_q, size_in_d, size_out_q, size_out_d, spp_q, spp_d;
    logic [SIZE_W-1:0] pend_in_q, pend_in_d, pend_out_q, pend_out_d, pend_spp_q, pend_spp_d;
    logic [SIZE_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic [31:0]       vec_in_q, vec_in_d, vec_out_q, vec_out_d;
    logic              hdr_stall_q, hdr_stall_d, pad_q, pad_d;
    logic [SIZE_W-1:0] wr_val;
    logic              wr_ok, in_last, gate_in, m_fire, end_vec, end_pkt, s_fire, idle, promote;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

`ifndef NNET_FRAMER_PAD_EN
    logic unused_tlast;
    assign unused_tlast = i_tlast;
`endif

    nnet_hdr_fifo #(.DEPTH(HDR_DEPTH), .W(TUSER_W)) u_hdr_fifo (
        .clk   (ce_clk),
        .rst_n (ce_rst_n),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_tuser),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (o_tuser)
    );

    always_comb begin
        // Writes of 0, or of values that do not fit in SIZE_W, are dropped.
        wr_val     = set_data[SIZE_W-1:0];
        wr_ok      = set_stb && (wr_val != '0) && (32'(wr_val) == set_data);
        pend_in_d  = (wr_ok && set_addr == 8'(SR_BASE + SR_OFF_SIZE_IN))  ? wr_val : pend_in_q;
        pend_out_d = (wr_ok && set_addr == 8'(SR_BASE + SR_OFF_SIZE_OUT)) ? wr_val : pend_out_q;
        pend_spp_d = (wr_ok && set_addr == 8'(SR_BASE + SR_OFF_SPP))      ? wr_val : pend_spp_q;
        // Input side: a new vector may not start without a free header slot.
        in_last = in_cnt_q == size_in_q - ONE;
        gate_in = (in_cnt_q == '0) && fifo_full;
`ifdef NNET_FRAMER_PAD_EN
        m_axis_tvalid = pad_q || (i_tvalid && !gate_in);
        m_axis_tdata  = pad_q ? '0 : i_tdata;
        i_tready      = m_axis_tready && !gate_in && !pad_q;
        m_fire        = m_axis_tvalid && m_axis_tready;
        pad_d         = clear ? 1'b0 :
                        pad_q ? !(m_fire && in_last) :
                        (i_tvalid && i_tready && i_tlast && !in_last);
`else
        m_axis_tvalid = i_tvalid && !gate_in;
        m_axis_tdata  = i_tdata;
        i_tready      = m_axis_tready && !gate_in;
        m_fire        = m_axis_tvalid && m_axis_tready;
        pad_d         = 1'b0;
`endif
        m_axis_tlast = m_axis_tvalid && in_last;
        fifo_push    = m_fire && (in_cnt_q == '0);
        in_cnt_d     = clear ? '0 : m_fire ? (in_last ? '0 : in_cnt_q + ONE) : in_cnt_q;
        vec_in_d     = vec_in_q + 32'(m_fire && in_last);
        // Output side: results are held off until their header is available.
        end_vec       = out_cnt_q == size_out_q - ONE;
        end_pkt       = pkt_cnt_q == spp_q - ONE;
        o_tvalid      = s_axis_tvalid && !fifo_empty;
        s_axis_tready = o_tready && !fifo_empty;
        o_tdata       = DATA_W'(s_axis_tdata);
        o_tlast       = o_tvalid && (end_vec || end_pkt);
        s_fire        = o_tvalid && o_tready;
        fifo_pop      = s_fire && end_vec;
        out_cnt_d     = clear ? '0 : s_fire ? (end_vec ? '0 : out_cnt_q + ONE) : out_cnt_q;
        pkt_cnt_d     = clear ? '0 : s_fire ? ((end_vec || end_pkt) ? '0 : pkt_cnt_q + ONE) : pkt_cnt_q;
        vec_out_d     = vec_out_q + 32'(fifo_pop);
        hdr_stall_d   = hdr_stall_q || (s_axis_tvalid && fifo_empty);
        // Settings change only between vectors; an input beat this cycle counts as busy.
        idle = (in_cnt_q == '0) && (out_cnt_q == '0) && (pkt_cnt_q == '0) && fifo_empty && !m_fire && !pad_q;
        promote    = clear || idle;
        size_in_d  = promote ? pend_in_d  : size_in_q;
        size_out_d = promote ? pend_out_d : size_out_q;
        spp_d      = promote ? pend_spp_d : spp_q;
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            size_in_q   <= SIZE_W'(DEF_SIZE);
            size_out_q  <= SIZE_W'(DEF_SIZE);
            spp_q       <= SIZE_W'(DEF_SIZE);
            pend_in_q   <= SIZE_W'(DEF_SIZE);
            pend_out_q  <= SIZE_W'(DEF_SIZE);
            pend_spp_q  <= SIZE_W'(DEF_SIZE);
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pkt_cnt_q   <= '0;
            vec_in_q    <= '0;
            vec_out_q   <= '0;
            hdr_stall_q <= 1'b0;
            pad_q       <= 1'b0;
        end else begin
            size_in_q   <= size_in_d;
            size_out_q  <= size_out_d;
            spp_q       <= spp_d;
            pend_in_q   <= pend_in_d;
            pend_out_q  <= pend_out_d;
            pend_spp_q  <= pend_spp_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            vec_in_q    <= vec_in_d;
            vec_out_q   <= vec_out_d;
            hdr_stall_q <= hdr_stall_d;
            pad_q       <= pad_d;
        end
    end

    assign size_in     = size_in_q;
    assign size_out    = size_out_q;
    assign spp         = spp_q;
    assign vec_in_cnt  = vec_in_q;
    assign vec_out_cnt = vec_out_q;
    assign hdr_stall   = hdr_stall_q;
endmodule

// File: tb/tb_nnet_vector_framer.sv
// tb_nnet_vector_framer: directed self-checking bench for nnet_vector_framer.
module tb_nnet_vector_framer;
    logic         ce_clk = 1'b0;
    logic         ce_rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         set_stb = 1'b0;
    logic [7:0]   set_addr = '0;
    logic [31:0]  set_data = '0;
    logic [31:0]  i_tdata = '0;
    logic         i_tlast = 1'b0;
    logic         i_tvalid = 1'b0;
    logic         i_tready;
    logic [127:0] i_tuser = '0;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tlast, m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [15:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [31:0]  o_tdata;
    logic         o_tlast, o_tvalid;
    logic         o_tready = 1'b0;
    logic [127:0] o_tuser;
    logic [15:0]  size_in, size_out, spp;
    logic [31:0]  vec_in_cnt, vec_out_cnt;
    logic         hdr_stall;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] TA = {4{32'hA5A5_0001}};
    localparam logic [127:0] TB = {4{32'hB6B6_0002}};
    localparam logic [127:0] TC = {4{32'hC7C7_0003}};
    localparam logic [127:0] TE = {4{32'hE9E9_0005}};

    nnet_vector_framer dut (
        .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tuser(i_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tuser(o_tuser),
        .size_in(size_in), .size_out(size_out), .spp(spp),
        .vec_in_cnt(vec_in_cnt), .vec_out_cnt(vec_out_cnt), .hdr_stall(hdr_stall)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct {
        logic         iv;
        logic [31:0]  id;
        logic [127:0] iu;
        logic         mr, sv;
        logic [15:0]  sd;
        logic         orr;
        logic [5:0]   fl;   // {m_tvalid, m_tlast, i_tready, o_tvalid, o_tlast, s_tready}
        logic [31:0]  md, od;
        logic [127:0] ou;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic [127:0] iu,
                                input logic mr, input logic sv, input logic [15:0] sd, input logic orr,
                                input logic [5:0] fl, input logic [31:0] md, input logic [31:0] od,
                                input logic [127:0] ou);
        vec_t v;
        v.iv = iv; v.id = id; v.iu = iu; v.mr = mr; v.sv = sv; v.sd = sd; v.orr = orr;
        v.fl = fl; v.md = md; v.od = od; v.ou = ou;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick();
        set_stb = 1'b0;
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = mk(1, 32'h100, TA, 1, 0, 16'h0,  0, 6'b101000, 32'h100, 32'h0,  '0);
        tbl[1]  = mk(1, 32'h101, TA, 1, 0, 16'h0,  0, 6'b101000, 32'h101, 32'h0,  TA);
        tbl[2]  = mk(1, 32'h102, TA, 1, 0, 16'h0,  0, 6'b101000, 32'h102, 32'h0,  TA);
        tbl[3]  = mk(1, 32'h103, TA, 1, 0, 16'h0,  0, 6'b111000, 32'h103, 32'h0,  TA);
        tbl[4]  = mk(1, 32'h104, TB, 1, 0, 16'h0,  0, 6'b101000, 32'h104, 32'h0,  TA);
        tbl[5]  = mk(1, 32'h105, TB, 1, 0, 16'h0,  0, 6'b101000, 32'h105, 32'h0,  TA);
        tbl[6]  = mk(1, 32'h106, TB, 1, 0, 16'h0,  0, 6'b101000, 32'h106, 32'h0,  TA);
        tbl[7]  = mk(1, 32'h107, TB, 1, 0, 16'h0,  0, 6'b111000, 32'h107, 32'h0,  TA);
        tbl[8]  = mk(0, 32'h0,   '0, 1, 1, 16'h50, 1, 6'b001101, 32'h0,   32'h50, TA);
        tbl[9]  = mk(0, 32'h0,   '0, 1, 1, 16'h51, 1, 6'b001111, 32'h0,   32'h51, TA);
        tbl[10] = mk(0, 32'h0,   '0, 1, 1, 16'h52, 1, 6'b001101, 32'h0,   32'h52, TB);
        tbl[11] = mk(0, 32'h0,   '0, 1, 1, 16'hFFFF, 1, 6'b001111, 32'h0, 32'hFFFF, TB);

        // Reset state
        o_tready = 1'b1;
        #12;
        chk("rst_flags", {m_axis_tvalid, m_axis_tlast, i_tready, o_tvalid, o_tlast, s_axis_tready}, 6'b0);
        chk("rst_o_tuser", o_tuser, '0);
        chk("rst_sizes", {size_in, size_out, spp}, {16'd1, 16'd1, 16'd1});
        chk("rst_cnts", {vec_in_cnt, vec_out_cnt, 31'b0, hdr_stall}, '0);
        @(negedge ce_clk);
        ce_rst_n = 1'b1;
        tick();
        o_tready = 1'b0;

        // Two vectors of 4 in, 2 results each in packets of 2
        wr(8'd129, 4);
        chk("size_in_wr", size_in, 4);
        wr(8'd130, 2);
        wr(8'd131, 2);
        chk("size_out_spp", {size_out, spp}, {16'd2, 16'd2});
        for (int k = 0; k < 12; k++) begin
            i_tvalid = tbl[k].iv; i_tdata = tbl[k].id; i_tuser = tbl[k].iu;
            m_axis_tready = tbl[k].mr; s_axis_tvalid = tbl[k].sv; s_axis_tdata = tbl[k].sd;
            o_tready = tbl[k].orr;
            #1;
            chk($sformatf("flags[%0d]", k),
                {m_axis_tvalid, m_axis_tlast, i_tready, o_tvalid, o_tlast, s_axis_tready}, tbl[k].fl);
            chk($sformatf("m_tdata[%0d]", k), m_axis_tdata, tbl[k].md);
            chk($sformatf("o_tdata[%0d]", k), o_tdata, tbl[k].od);
            chk($sformatf("o_tuser[%0d]", k), o_tuser, tbl[k].ou);
            tick();
        end
        s_axis_tvalid = 1'b0; i_tvalid = 1'b0;
        chk("vec_cnts_1", {vec_in_cnt, vec_out_cnt}, {32'd2, 32'd2});

        // size_out=5, spp=2: packets 2,2,1 with one header
        begin
            logic [4:0] exp_l;
            exp_l = 5'b11010;
            wr(8'd130, 5);
            wr(8'd129, 1);
            chk("size_in_1", size_in, 1);
            i_tvalid = 1'b1; i_tuser = TC; i_tdata = 32'h77;
            #1;
            chk("t2_m_tlast", m_axis_tlast, 1'b1);
            tick();
            i_tvalid = 1'b0;
            s_axis_tvalid = 1'b1; o_tready = 1'b1;
            for (int k = 0; k < 5; k++) begin
                s_axis_tdata = 16'(k);
                #1;
                chk($sformatf("t2_tlast[%0d]", k), o_tlast, exp_l[k]);
                chk($sformatf("t2_tuser[%0d]", k), o_tuser, TC);
                tick();
            end
            s_axis_tvalid = 1'b0;
            chk("t2_vec_out", vec_out_cnt, 3);
        end

        // Header FIFO full: 5th vector held off until a result drains
        wr(8'd130, 1);
        i_tvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_tuser = 128'hD0 + 128'(k < 4 ? k : 4);
            #1;
            chk($sformatf("t3_ready[%0d]", k), {i_tready, m_axis_tvalid}, k < 4 ? 2'b11 : 2'b00);
            tick();
        end
        s_axis_tvalid = 1'b1;
        #1;
        chk("t3_drain0", {o_tvalid, o_tlast, i_tready}, 3'b110);
        chk("t3_tuser0", o_tuser, 128'hD0);
        tick();
        s_axis_tvalid = 1'b0;
        #1;
        chk("t3_ready_after", i_tready, 1'b1);
        tick();
        i_tvalid = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            chk($sformatf("t3_tuser[%0d]", k), o_tuser, 128'hD0 + 128'(k));
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("t3_cnts", {vec_in_cnt, vec_out_cnt}, {32'd8, 32'd8});

        // Deferred register promotion
        wr(8'd129, 4);
        chk("t4_size4", size_in, 4);
        i_tvalid = 1'b1; i_tuser = TE;
        tick(); tick();
        i_tvalid = 1'b0;
        wr(8'd129, 8);
        chk("t4_hold_mid", size_in, 4);
        wr(8'd129, 0);
        i_tvalid = 1'b1;
        tick(); tick();
        i_tvalid = 1'b0;
        chk("t4_hold_out", size_in, 4);
        s_axis_tvalid = 1'b1;
        #1;
        chk("t4_tuser", o_tuser, TE);
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("t4_promoted", size_in, 8);
        wr(8'd129, 0);
        chk("t4_zero_ignored", size_in, 8);

        // Result with no header: gated, sticky stall, survives clear
        chk("t5_stall_pre", hdr_stall, 1'b0);
        s_axis_tvalid = 1'b1;
        #1;
        chk("t5_gated", {o_tvalid, s_axis_tready}, 2'b00);
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("t5_sticky", hdr_stall, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_after_clear", {vec_in_cnt, vec_out_cnt, 31'b0, hdr_stall}, {32'd9, 32'd9, 32'd1});

`ifdef NNET_FRAMER_PAD_EN
        // Short vector zero-padded to size_in
        wr(8'd129, 4);
        m_axis_tready = 1'b1; i_tvalid = 1'b1; i_tuser = TA;
        i_tdata = 32'h11; i_tlast = 1'b0;
        #1;
        chk("p_d0", {m_axis_tdata, 1'b0, i_tready}, {32'h11, 2'b01});
        tick();
        i_tdata = 32'h22; i_tlast = 1'b1;
        #1;
        chk("p_d1", {m_axis_tdata, m_axis_tlast, i_tready}, {32'h22, 2'b01});
        tick();
        i_tdata = 32'h33; i_tlast = 1'b0;
        #1;
        chk("p_pad0", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, i_tready}, {32'h0, 3'b100});
        tick();
        #1;
        chk("p_pad1", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, i_tready}, {32'h0, 3'b110});
        tick();
        #1;
        chk("p_resume", {m_axis_tdata, i_tready}, {32'h33, 1'b1});
        i_tvalid = 1'b0;
        chk("p_vec_in", vec_in_cnt, 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
